// File: rtl/game_pkg.sv
// Shared game constants and helpers for the obstacle and scoring blocks.
package game_pkg;

   localparam int COORD_W          = 10;
   localparam int SCREEN_RESPAWN_X = 900;
   localparam int SCREEN_LEFT_X    = 80;

   localparam logic [6:0] LFSR_SEED = 7'h5A;
   // x^7 + x^6 + 1: feedback from bits 6 and 5
   localparam logic [6:0] LFSR_TAPS = 7'h60;

   function automatic logic [6:0] rotl7(input logic [6:0] v, input int unsigned r);
      logic [13:0] d;
      d = {v, v} << r;
      return d[13:7];
   endfunction

endpackage

// File: rtl/lfsr7.sv
// Free-running 7-bit maximal-length LFSR; advances on every non-reset edge.
module lfsr7
   import game_pkg::*;
(
   input  logic       clk10,
   input  logic       clr,
   output logic [6:0] out
);

   always_ff @(posedge clk10) begin
      if (!clr) out <= LFSR_SEED;
      else      out <= {out[5:0], ^(out & LFSR_TAPS)};
   end

endmodule

// File: rtl/pillar_field.sv
// Obstacle manager: scrolls NUM_PILLARS pillars, respawns them with random gap
// heights, and keeps a saturating score plus a score-driven scroll speed.
module pillar_field
   import game_pkg::*;
#(
   parameter int NUM_PILLARS = 3,
   parameter int X_W         = COORD_W,
   parameter int SCORE_W     = 10,
   parameter int START_X     = 400,
   parameter int SPACING     = 250,
   parameter int RESPAWN_X   = SCREEN_RESPAWN_X,
   parameter int LEFT_X      = SCREEN_LEFT_X,
   parameter int Y_INIT      = 200,
   parameter int Y_MIN       = 150,
   parameter int SPEED_INIT  = 5,
   parameter int SPEED_MAX   = 12,
   parameter int SCORE_STEP  = 8
)(
   input  logic                       clk10,
   input  logic                       clr,
   input  logic                       game_over,
   input  logic                       move_en,
   output logic [NUM_PILLARS*X_W-1:0] pillar_x,
   output logic [NUM_PILLARS*X_W-1:0] pillar_y,
   output logic [SCORE_W-1:0]         score,
   output logic [4:0]                 speed,
   output logic                       scored
);

   // wide enough for (SCORE_STEP-1) + up to 8 simultaneous respawns
   localparam int LVL_W = $clog2(SCORE_STEP + 9);
   localparam logic [SCORE_W+3:0] SCORE_MAX = {4'b0, {SCORE_W{1'b1}}};

   if (LEFT_X < SPEED_MAX)                 begin : g_chk_left  $error("LEFT_X must be >= SPEED_MAX"); end
   if (SCORE_STEP < 1)                     begin : g_chk_step  $error("SCORE_STEP must be >= 1"); end
   if (NUM_PILLARS < 1 || NUM_PILLARS > 8) begin : g_chk_num   $error("NUM_PILLARS must be 1..8"); end

   logic [6:0]                        rnd;
   logic                              step;
   logic [NUM_PILLARS-1:0]            resp;
   logic [NUM_PILLARS-1:0][X_W-1:0]   px, py, nx, ny;
   logic [3:0]                        n;
   logic [SCORE_W+3:0]                score_sum;
   logic [LVL_W-1:0]                  lvl, lvl_sum, lvl_nxt;
   logic                              lvl_up;

   lfsr7 u_lfsr (
      .clk10 (clk10),
      .clr   (clr),
      .out   (rnd)
   );

   assign step = clr & move_en & ~game_over;

   for (genvar g = 0; g < NUM_PILLARS; g++) begin : g_pil
      assign resp[g] = px[g] <= X_W'(LEFT_X);
      assign nx[g]   = resp[g] ? X_W'(RESPAWN_X) : px[g] - X_W'(speed);
      // per-index rotation keeps simultaneous respawns at different heights
      assign ny[g]   = resp[g] ? X_W'(Y_MIN) + X_W'(rotl7(rnd, g % 7)) : py[g];
   end

   always_comb begin
      n = '0;
      for (int i = 0; i < NUM_PILLARS; i++) n = n + 4'(resp[i]);
   end

   assign score_sum = {4'b0, score} + (SCORE_W+4)'(n);
   assign lvl_sum   = lvl + LVL_W'(n);
   assign lvl_up    = lvl_sum >= LVL_W'(SCORE_STEP);

   always_comb begin
      lvl_nxt = lvl_sum;
      if (lvl_up) begin
         lvl_nxt = lvl_sum - LVL_W'(SCORE_STEP);
         if (lvl_nxt > LVL_W'(SCORE_STEP - 1)) lvl_nxt = LVL_W'(SCORE_STEP - 1);
      end
   end

   always_ff @(posedge clk10) begin
      if (!clr) begin
         for (int i = 0; i < NUM_PILLARS; i++) begin
            px[i] <= X_W'(START_X + i * SPACING);
            py[i] <= X_W'(Y_INIT);
         end
         score  <= '0;
         lvl    <= '0;
         speed  <= 5'(SPEED_INIT);
         scored <= 1'b0;
      end else if (step) begin
         px     <= nx;
         py     <= ny;
         score  <= (score_sum > SCORE_MAX) ? '1 : score_sum[SCORE_W-1:0];
         lvl    <= lvl_nxt;
         if (lvl_up && speed < 5'(SPEED_MAX)) speed <= speed + 5'd1;
         scored <= n != 4'd0;
      end else begin
         scored <= 1'b0;
      end
   end

   assign pillar_x = px;
   assign pillar_y = py;

endmodule

// File: tb/tb_pillar_field.sv
// Randomized self-checking bench: three pillar_field configurations driven in
// lockstep and compared every edge against an integer reference model.
module tb_pillar_field;

   logic clk10 = 1'b0;
   logic clr = 1'b0, game_over = 1'b0, move_en = 1'b1;

   logic [29:0] px[3], py[3];
   logic [9:0]  sc0, sc1;
   logic [3:0]  sc2;
   logic [4:0]  sp[3];
   logic        scd[3];

   int n_chk = 0, n_fail = 0;

   always #5 clk10 = ~clk10;

   pillar_field u_d0 (
      .clk10(clk10), .clr(clr), .game_over(game_over), .move_en(move_en),
      .pillar_x(px[0]), .pillar_y(py[0]), .score(sc0), .speed(sp[0]), .scored(scd[0]));

   pillar_field #(.START_X(80), .SPACING(0)) u_d1 (
      .clk10(clk10), .clr(clr), .game_over(game_over), .move_en(move_en),
      .pillar_x(px[1]), .pillar_y(py[1]), .score(sc1), .speed(sp[1]), .scored(scd[1]));

   pillar_field #(.SCORE_W(4), .SCORE_STEP(2), .START_X(80), .SPACING(0)) u_d2 (
      .clk10(clk10), .clr(clr), .game_over(game_over), .move_en(move_en),
      .pillar_x(px[2]), .pillar_y(py[2]), .score(sc2), .speed(sp[2]), .scored(scd[2]));

   // reference model state, one row per configuration
   int P_START[3] = '{400, 80, 80};
   int P_SP[3]    = '{250, 0, 0};
   int P_SMAX[3]  = '{1023, 1023, 15};
   int P_STEP[3]  = '{8, 8, 2};
   int mx[3][3], my[3][3];
   int msc[3], mlv[3], msp[3], mscd[3], mn[3];
   int mlfsr;

   task automatic chk(input string tag, input logic [31:0] got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic int rotl(input int v, input int r);
      return ((v << r) | (v >> (7 - r))) & 127;
   endfunction

   function automatic logic [31:0] dscore(input int k);
      if (k == 0) return 32'(sc0);
      if (k == 1) return 32'(sc1);
      return 32'(sc2);
   endfunction

   function automatic logic [31:0] dx(input int k, input int i);
      return 32'(px[k][i*10 +: 10]);
   endfunction

   function automatic logic [31:0] dy(input int k, input int i);
      return 32'(py[k][i*10 +: 10]);
   endfunction

   task automatic model_edge();
      int s;
      for (int k = 0; k < 3; k++) begin
         mn[k] = 0;
         if (!clr) begin
            for (int i = 0; i < 3; i++) begin
               mx[k][i] = (P_START[k] + i * P_SP[k]) % 1024;
               my[k][i] = 200;
            end
            msc[k] = 0; mlv[k] = 0; msp[k] = 5; mscd[k] = 0;
         end else if (move_en && !game_over) begin
            for (int i = 0; i < 3; i++) begin
               if (mx[k][i] <= 80) begin
                  mx[k][i] = 900;
                  my[k][i] = 150 + rotl(mlfsr, i % 7);
                  mn[k]++;
               end else begin
                  mx[k][i] = mx[k][i] - msp[k];
               end
            end
            msc[k] = imin(msc[k] + mn[k], P_SMAX[k]);
            s = mlv[k] + mn[k];
            if (s >= P_STEP[k]) begin
               msp[k] = imin(msp[k] + 1, 12);
               mlv[k] = imin(s - P_STEP[k], P_STEP[k] - 1);
            end else begin
               mlv[k] = s;
            end
            mscd[k] = (mn[k] > 0) ? 1 : 0;
         end else begin
            mscd[k] = 0;
         end
      end
      if (!clr) mlfsr = 'h5A;
      else      mlfsr = ((mlfsr << 1) | (((mlfsr >> 6) ^ (mlfsr >> 5)) & 1)) & 127;
   endtask

   task automatic check_all();
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("d%0d_x%0d", k, i), dx(k, i), mx[k][i]);
            chk($sformatf("d%0d_y%0d", k, i), dy(k, i), my[k][i]);
         end
         chk($sformatf("d%0d_score", k), dscore(k), msc[k]);
         chk($sformatf("d%0d_speed", k), 32'(sp[k]), msp[k]);
         chk($sformatf("d%0d_scored", k), 32'(scd[k]), mscd[k]);
      end
   endtask

   task automatic tick();
      int prev_sp, prev_sc;
      prev_sp = msp[2];
      prev_sc = msc[2];
      @(posedge clk10);
      model_edge();
      #1;
      check_all();
      if (clr && mn[2] == 3) begin
         chk("d2_speed_step", 32'(sp[2]), imin(prev_sp + 1, 12));
         chk("d2_score_step", 32'(sc2), imin(prev_sc + 3, 15));
      end
   endtask

   initial begin
      logic [31:0] sx, sy, ss, sv;
      bit found;

      // reset held for two edges
      clr = 1'b0; move_en = 1'b1; game_over = 1'b0;
      tick(); tick();
      chk("rst_x0", dx(0, 0), 400);
      chk("rst_x1", dx(0, 1), 650);
      chk("rst_x2", dx(0, 2), 900);
      for (int i = 0; i < 3; i++) chk($sformatf("rst_y%0d", i), dy(0, i), 200);
      chk("rst_score", dscore(0), 0);
      chk("rst_speed", 32'(sp[0]), 5);
      chk("rst_scored", 32'(scd[0]), 0);

      clr = 1'b1;
      tick();
      chk("step1_x0", dx(0, 0), 395);
      chk("step1_x1", dx(0, 1), 645);
      chk("step1_x2", dx(0, 2), 895);
      // simultaneous respawn configuration
      for (int i = 0; i < 3; i++) chk($sformatf("sim_x%0d", i), dx(1, i), 900);
      chk("sim_y01_distinct", 32'(dy(1, 0) != dy(1, 1)), 1);
      chk("sim_y02_distinct", 32'(dy(1, 0) != dy(1, 2)), 1);
      chk("sim_y12_distinct", 32'(dy(1, 1) != dy(1, 2)), 1);
      chk("sim_score", dscore(1), 3);

      // first respawn of pillar 0
      repeat (63) tick();
      chk("x0_at_left", dx(0, 0), 80);
      tick();
      chk("resp_x0", dx(0, 0), 900);
      chk("resp_score", dscore(0), 1);
      chk("resp_scored", 32'(scd[0]), 1);
      move_en = 1'b0;
      tick();
      chk("pulse_end", 32'(scd[0]), 0);
      chk("hold_x0", dx(0, 0), 900);
      move_en = 1'b1;

      // freeze
      sx = dx(0, 0); sy = dy(0, 0); ss = dscore(0); sv = 32'(sp[0]);
      game_over = 1'b1;
      repeat (10) tick();
      chk("frz_x0", dx(0, 0), int'(sx));
      chk("frz_y0", dy(0, 0), int'(sy));
      chk("frz_score", dscore(0), int'(ss));
      chk("frz_speed", 32'(sp[0]), int'(sv));
      game_over = 1'b0;
      tick();
      chk("resume_x0", dx(0, 0), int'(sx) - int'(sv));

      // random run without reset, long enough for saturation in config 2
      for (int t = 0; t < 1500; t++) begin
         move_en   = ($urandom_range(0, 9) < 8);
         game_over = ($urandom_range(0, 9) == 0);
         tick();
      end
      chk("d2_score_sat", 32'(sc2), 15);
      chk("d2_speed_cap", 32'(sp[2]), 12);

      // mid-game reset while a respawn is due
      move_en = 1'b1; game_over = 1'b0;
      found = 1'b0;
      for (int t = 0; t < 300 && !found; t++) begin
         if (mx[0][0] <= 80 || mx[0][1] <= 80 || mx[0][2] <= 80) found = 1'b1;
         else tick();
      end
      chk("resp_due_found", 32'(found), 1);
      clr = 1'b0;
      tick();
      chk("midrst_score", dscore(0), 0);
      chk("midrst_scored", 32'(scd[0]), 0);
      chk("midrst_x0", dx(0, 0), 400);
      chk("midrst_speed", 32'(sp[0]), 5);
      clr = 1'b1;

      // random run with occasional resets
      for (int t = 0; t < 300; t++) begin
         clr       = ($urandom_range(0, 29) != 0);
         move_en   = ($urandom_range(0, 9) < 8);
         game_over = ($urandom_range(0, 9) == 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
